// File: rtl/jk_ff_bank.sv
// jk_ff_bank: a bank of WIDTH independent flip-flops whose per-bit behaviour
// is selected at run time by mode (00 JK, 01 SR, 10 D, 11 T).
// q is registered, q_n is its combinational inverse, chg pulses for one
// cycle whenever q takes a new value (reset loads excluded).
// Optional feature: define JK_FF_BANK_ERR_EN to enable a sticky err flag
// that records illegal SR inputs (S=R=1 on any bit during an enabled cycle).
// Without the macro err is constant 0 and err_clr is ignored.
module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             chg,
    output logic             err
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;
    logic             err_q, err_d;

    // Per-bit next state for the selected mode; every bit is independent,
    // so the whole bank is expressed with bitwise vector operations.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                // JK: set where J & ~Q, keep where ~K & Q; 11 toggles.
                MODE_JK: q_d = (j & ~q_q) | (~k & q_q);
                // SR: set on S-only, clear on R-only, hold on 00 and on 11.
                MODE_SR: q_d = (q_q | (j & ~k)) & ~(k & ~j);
                MODE_D:  q_d = j;
                MODE_T:  q_d = q_q ^ j;
                default: q_d = q_q;
            endcase
        end
    end

    // chg reports any bit difference between the new and current value;
    // with en=0 q_d equals q_q so this is naturally 0.
    always_comb begin
        chg_d = (q_d != q_q);
    end

`ifdef JK_FF_BANK_ERR_EN
    // Sticky error: a new illegal SR input wins over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (en && (mode == MODE_SR) && (|(j & k))) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end
`else
    // Feature disabled: err never sets and err_clr has no effect.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_comb begin
        err_d = 1'b0;
    end
`endif

    // State registers; synchronous reset overrides every other input and
    // discards the update that would otherwise be taken on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RST_VAL;
            chg_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            err_q <= err_d;
        end
    end

    assign q   = q_q;
    assign q_n = ~q_q;
    assign chg = chg_q;
    assign err = err_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Testbench for jk_ff_bank (WIDTH=8, RST_VAL=0). The driver applies inputs
// on the falling edge and pushes the reference model's expected outputs;
// the monitor pops and compares one entry after every rising edge.
module tb_jk_ff_bank;

    localparam int         W       = 8;
    localparam logic [W-1:0] RST_V = 8'h00;
`ifdef JK_FF_BANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         err_clr;
    logic [W-1:0] q;
    logic [W-1:0] q_n;
    logic         chg;
    logic         err;

    // expected entry layout: {q, chg, err}
    logic [W+1:0] exp_q[$];

    int checks;
    int errors;

    // reference model state
    logic [W-1:0] m_q;
    logic         m_err;

    jk_ff_bank #(.WIDTH(W), .RST_VAL(RST_V)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .err_clr (err_clr),
        .q       (q),
        .q_n     (q_n),
        .chg     (chg),
        .err     (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // One flip-flop at a time, straight from the behaviour table.
    function automatic logic model_bit(input logic [1:0] md, input logic jb,
                                       input logic kb, input logic cur);
        logic r;
        r = cur;
        case (md)
            2'd0: begin
                if (jb && !kb)      r = 1'b1;
                else if (!jb && kb) r = 1'b0;
                else if (jb && kb)  r = !cur;
            end
            2'd1: begin
                if (jb && !kb)      r = 1'b1;
                else if (!jb && kb) r = 1'b0;
            end
            2'd2: r = jb;
            default: r = jb ? !cur : cur;
        endcase
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r_i, input logic en_i, input logic [1:0] md_i,
                         input logic [W-1:0] j_i, input logic [W-1:0] k_i,
                         input logic clr_i);
        logic [W-1:0] nq;
        logic         nchg;
        logic         illegal;
        @(negedge clk);
        rst = r_i; en = en_i; mode = md_i; j = j_i; k = k_i; err_clr = clr_i;
        if (r_i) begin
            m_q   = RST_V;
            m_err = 1'b0;
            nchg  = 1'b0;
        end else begin
            nq = m_q;
            illegal = 1'b0;
            if (en_i) begin
                for (int i = 0; i < W; i++) begin
                    nq[i] = model_bit(md_i, j_i[i], k_i[i], m_q[i]);
                    if (md_i == 2'd1 && j_i[i] && k_i[i]) illegal = 1'b1;
                end
            end
            nchg = (nq != m_q);
            m_q  = nq;
            if (ERR_EN) begin
                if (illegal)    m_err = 1'b1;
                else if (clr_i) m_err = 1'b0;
            end else begin
                m_err = 1'b0;
            end
        end
        exp_q.push_back({m_q, nchg, m_err});
    endtask

    // Direct check of q against a literal value, sampled after the edge.
    task automatic check_q(input string name, input logic [W-1:0] want);
        @(posedge clk);
        #1;
        checks++;
        if (q !== want) begin
            errors++;
            $display("FAIL %s: q=%h expected %h", name, q, want);
        end
    endtask

    task automatic check_err(input string name, input logic want);
        @(posedge clk);
        #1;
        checks++;
        if (err !== want) begin
            errors++;
            $display("FAIL %s: err=%b expected %b", name, err, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W+1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (q !== e[W+1:2]) begin
                    errors++;
                    $display("FAIL q: got %h expected %h at %0t", q, e[W+1:2], $time);
                end
                checks++;
                if (q_n !== ~e[W+1:2]) begin
                    errors++;
                    $display("FAIL q_n: got %h expected %h at %0t", q_n, ~e[W+1:2], $time);
                end
                checks++;
                if (chg !== e[1]) begin
                    errors++;
                    $display("FAIL chg: got %b expected %b at %0t", chg, e[1], $time);
                end
                checks++;
                if (err !== e[0]) begin
                    errors++;
                    $display("FAIL err: got %b expected %b at %0t", err, e[0], $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; errors = 0;
        m_q = RST_V; m_err = 1'b0;
        rst = 1'b1; en = 1'b0; mode = 2'd0; j = '0; k = '0; err_clr = 1'b0;

        drive(1, 0, 2'd0, 8'h00, 8'h00, 0);
        // reset from a non-reset value
        drive(0, 1, 2'd2, 8'h5A, 8'h00, 0);
        check_q("load_5a", 8'h5A);
        drive(1, 1, 2'd3, 8'hFF, 8'hFF, 1);
        check_q("reset_q", 8'h00);

        // JK from 0F
        drive(0, 1, 2'd2, 8'h0F, 8'h00, 0);
        drive(0, 1, 2'd0, 8'hF0, 8'h0F, 0);
        check_q("jk_set_clr", 8'hF0);
        drive(0, 1, 2'd0, 8'hFF, 8'hFF, 0);
        check_q("jk_toggle", 8'h0F);
        drive(0, 1, 2'd0, 8'h00, 8'h00, 0);
        check_q("jk_hold", 8'h0F);

        // SR with an illegal bit, then sticky hold, then clear
        drive(0, 1, 2'd2, 8'h00, 8'h00, 0);
        drive(0, 1, 2'd1, 8'h81, 8'h01, 0);
        check_q("sr_illegal_q", 8'h80);
        for (int n = 0; n < 5; n++) drive(0, 1, 2'd1, 8'h00, 8'h00, 0);
        check_err("sr_err_sticky", ERR_EN);
        drive(0, 1, 2'd1, 8'h00, 8'h00, 1);
        check_err("sr_err_clr", 1'b0);

        // D then T twice
        drive(0, 1, 2'd2, 8'hA5, 8'h00, 0);
        check_q("d_a5", 8'hA5);
        drive(0, 1, 2'd3, 8'hFF, 8'h00, 0);
        check_q("t_first", 8'h5A);
        drive(0, 1, 2'd3, 8'hFF, 8'h00, 0);
        check_q("t_second", 8'hA5);

        // enable gate, including an illegal SR pattern that must not set err
        for (int n = 0; n < 3; n++) drive(0, 0, 2'd2, 8'h33, 8'h00, 0);
        check_q("en_gate", 8'hA5);
        drive(0, 0, 2'd1, 8'hFF, 8'hFF, 0);
        check_err("en_gate_err", 1'b0);

        // same-cycle set/clear: set wins
        drive(0, 1, 2'd1, 8'h01, 8'h01, 0);
        drive(0, 1, 2'd1, 8'h02, 8'h02, 1);
        check_err("set_wins", ERR_EN);
        // reset overrides an enabled D load
        drive(1, 1, 2'd2, 8'hFF, 8'h00, 0);
        check_q("rst_over_d", 8'h00);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 80),
                  2'($urandom_range(0, 3)),
                  W'($urandom),
                  W'($urandom),
                  ($urandom_range(0, 99) < 20));
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
